// File: rtl/nios_fprint_cpu_div_cell.sv
// nios_fprint_cpu_div_cell
//   Iterative radix-2 restoring integer divider for the Nios CPU datapath (DIV/DIVU).
//   It sits beside the multiply cell. It captures operands at E stage and returns the
//   quotient and remainder DATA_W+3 cycles after an accepted start. It holds busy
//   while the result is being computed.
//
// Ports
//   clk                in   clock, rising edge
//   reset              in   asynchronous active-high reset
//   E_div_start        in   request, sampled only while idle
//   E_div_cancel       in   pipeline flush, aborts any operation in flight
//   E_ctrl_div_signed  in   1 = two's-complement operands, 0 = unsigned
//   E_src1_div_cell    in   dividend
//   E_src2_div_cell    in   divisor
//   A_div_busy         out  high from PREP through FIX
//   A_div_done         out  one-cycle result-valid pulse
//   A_div_quot         out  quotient, held until the next done
//   A_div_rem          out  remainder, held until the next done
//   A_div_by_zero      out  divisor was zero for the held result
module nios_fprint_cpu_div_cell #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E_div_start,
  input  logic              E_div_cancel,
  input  logic              E_ctrl_div_signed,
  input  logic [DATA_W-1:0] E_src1_div_cell,
  input  logic [DATA_W-1:0] E_src2_div_cell,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quot,
  output logic [DATA_W-1:0] A_div_rem,
  output logic              A_div_by_zero
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] L_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  L_LAST = CNT_W'(DATA_W - 1);

  // Two's-complement negation
  function automatic logic [DATA_W-1:0] f_neg(input logic [DATA_W-1:0] x);
    f_neg = ~x + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Control state
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_quot;
  logic [DATA_W-1:0] r_rem;
  logic              r_by_zero;

  // Datapath state (no reset needed; always reloaded before use)
  logic              r_signed;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [DATA_W-1:0] r_dvd;    // shifts out dividend bits, shifts in quotient bits
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_prem;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_zero;
  logic              r_ovf;

  logic              w_s1_neg;
  logic              w_s2_neg;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_trial;
  logic              w_ge;
  logic [DATA_W-1:0] w_q_fix;
  logic [DATA_W-1:0] w_r_fix;
  logic [DATA_W-1:0] w_quot_out;
  logic [DATA_W-1:0] w_rem_out;

  assign w_s1_neg = r_signed & r_src1[DATA_W-1];
  assign w_s2_neg = r_signed & r_src2[DATA_W-1];

  // Trial subtract: a set top bit of the shifted remainder already exceeds any
  // divisor, otherwise the borrow out of the subtract decides.
  assign w_shift = {r_prem, r_dvd[DATA_W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_ge    = w_shift[DATA_W] | ~w_trial[DATA_W];

  assign w_q_fix = r_neg_q ? f_neg(r_dvd)  : r_dvd;
  assign w_r_fix = r_neg_r ? f_neg(r_prem) : r_prem;

  // Special cases override the sign-corrected iteration result
  always_comb begin
    w_quot_out = w_q_fix;
    w_rem_out  = w_r_fix;
    if (r_zero) begin
      w_quot_out = '1;
      w_rem_out  = r_src1;
    end else if (r_ovf) begin
      w_quot_out = L_MIN;
      w_rem_out  = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (E_div_start && !E_div_cancel) begin
          r_signed <= E_ctrl_div_signed;
          r_src1   <= E_src1_div_cell;
          r_src2   <= E_src2_div_cell;
        end
      end
      S_PREP: begin
        r_dvd   <= w_s1_neg ? f_neg(r_src1) : r_src1;
        r_dvs   <= w_s2_neg ? f_neg(r_src2) : r_src2;
        r_neg_q <= w_s1_neg ^ w_s2_neg;
        r_neg_r <= w_s1_neg;
        r_zero  <= (r_src2 == '0);
        r_ovf   <= r_signed && (r_src1 == L_MIN) && (r_src2 == '1);
        r_prem  <= '0;
      end
      S_ITER: begin
        r_prem <= w_ge ? w_trial[DATA_W-1:0] : w_shift[DATA_W-1:0];
        r_dvd  <= {r_dvd[DATA_W-2:0], w_ge};
      end
      default: ;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (E_div_start && !E_div_cancel) begin
            r_state <= S_PREP;
            r_busy  <= 1'b1;
          end
        end
        S_PREP: begin
          if (E_div_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_ITER;
            r_cnt   <= '0;
          end
        end
        S_ITER: begin
          if (E_div_cancel) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == L_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (E_div_cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_quot    <= w_quot_out;
            r_rem     <= w_rem_out;
            r_by_zero <= r_zero;
          end
        end
        S_DONE: begin
          // Starts are not sampled here; the next request is taken from IDLE
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign A_div_busy    = r_busy;
  assign A_div_done    = r_done;
  assign A_div_quot    = r_quot;
  assign A_div_rem     = r_rem;
  assign A_div_by_zero = r_by_zero;

endmodule

// File: tb/tb_nios_fprint_cpu_div_cell.sv
// Directed bench for nios_fprint_cpu_div_cell: latency, signed/unsigned results,
// divide-by-zero and overflow, ignored starts, cancel, async reset, edge sweep.
module tb_nios_fprint_cpu_div_cell;
  localparam int DW = 32;
  localparam logic [DW-1:0] MINV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          E_div_start;
  logic          E_div_cancel;
  logic          E_ctrl_div_signed;
  logic [DW-1:0] E_src1_div_cell;
  logic [DW-1:0] E_src2_div_cell;
  logic          A_div_busy;
  logic          A_div_done;
  logic [DW-1:0] A_div_quot;
  logic [DW-1:0] A_div_rem;
  logic          A_div_by_zero;

  int n_checks   = 0;
  int n_fail     = 0;
  int n_done     = 0;
  int n_exp_done = 0;

  nios_fprint_cpu_div_cell #(.DATA_W(DW), .CNT_W(6)) dut (
    .clk               (clk),
    .reset             (reset),
    .E_div_start       (E_div_start),
    .E_div_cancel      (E_div_cancel),
    .E_ctrl_div_signed (E_ctrl_div_signed),
    .E_src1_div_cell   (E_src1_div_cell),
    .E_src2_div_cell   (E_src2_div_cell),
    .A_div_busy        (A_div_busy),
    .A_div_done        (A_div_done),
    .A_div_quot        (A_div_quot),
    .A_div_rem         (A_div_rem),
    .A_div_by_zero     (A_div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (A_div_done === 1'b1) n_done++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference division written from the arithmetic definition
  task automatic ref_div(input logic sgn, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [DW-1:0] q, output logic [DW-1:0] r, output logic z);
    longint sa, sb, lq, lr;
    z = 1'b0;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sgn && a == MINV && b == '1) begin
      q = MINV; r = '0;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q = lq[DW-1:0];
      r = lr[DW-1:0];
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  // One complete operation; optionally pulses a second start at cycle N+5
  task automatic do_op(input string tag, input logic sgn, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [DW-1:0] eq,
                       input logic [DW-1:0] er, input logic ez, input logic glitch);
    int done_at;
    bit busy_ok;
    @(posedge clk); #1;
    E_ctrl_div_signed = sgn;
    E_src1_div_cell   = a;
    E_src2_div_cell   = b;
    E_div_start       = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    done_at = -1;
    busy_ok = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      if (glitch && j == 5) begin
        E_div_start = 1'b1; E_src1_div_cell = 32'h50; E_src2_div_cell = 32'd5;
      end
      if (glitch && j == 6) E_div_start = 1'b0;
      if (A_div_busy !== (j <= DW + 2)) busy_ok = 1'b0;
      if (A_div_done === 1'b1) begin done_at = j; break; end
    end
    n_exp_done++;
    chk({tag, "_latency"}, done_at, DW + 3);
    chk({tag, "_busy"}, busy_ok, 1'b1);
    chk({tag, "_quot"}, A_div_quot, eq);
    chk({tag, "_rem"}, A_div_rem, er);
    chk({tag, "_byzero"}, A_div_by_zero, ez);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, A_div_done, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] q0, r0, eq, er;
    logic          z0, ez;
    bit            saw_done;
    logic [DW-1:0] edges [7];

    reset = 1'b1;
    E_div_start = 1'b0; E_div_cancel = 1'b0; E_ctrl_div_signed = 1'b0;
    E_src1_div_cell = '0; E_src2_div_cell = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", A_div_busy, 1'b0);
    chk("rst_done", A_div_done, 1'b0);
    chk("rst_quot", A_div_quot, 32'h0);
    chk("rst_rem", A_div_rem, 32'h0);
    chk("rst_byzero", A_div_by_zero, 1'b0);
    reset = 1'b0;

    do_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    do_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
    do_op("u_div0", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b0);
    do_op("s_ovf", 1'b1, MINV, 32'hFFFF_FFFF, MINV, 32'h0, 1'b0, 1'b0);
    do_op("s_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("s_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);

    // Second start while busy is ignored
    do_op("ign_start", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 1'b1);

    // Cancel at N+10: idle at N+11, no done, outputs held
    q0 = A_div_quot; r0 = A_div_rem; z0 = A_div_by_zero;
    @(posedge clk); #1;
    E_ctrl_div_signed = 1'b0; E_src1_div_cell = 32'd100; E_src2_div_cell = 32'd7;
    E_div_start = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    saw_done = 1'b0;
    for (int j = 1; j <= 11; j++) begin
      if (j > 1) begin @(posedge clk); #1; end
      if (A_div_done === 1'b1) saw_done = 1'b1;
      if (j == 10) E_div_cancel = 1'b1;
      if (j == 11) begin
        chk("cancel_busy", A_div_busy, 1'b0);
        E_div_cancel = 1'b0;
      end
    end
    chk("cancel_nodone", saw_done, 1'b0);
    chk("cancel_quot", A_div_quot, q0);
    chk("cancel_rem", A_div_rem, r0);
    chk("cancel_byzero", A_div_by_zero, z0);
    do_op("after_cancel", 1'b0, 32'h50, 32'd5, 32'd16, 32'd0, 1'b0, 1'b0);

    // Start together with cancel in IDLE is dropped
    @(posedge clk); #1;
    E_div_start = 1'b1; E_div_cancel = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0; E_div_cancel = 1'b0;
    chk("start_cancel_busy", A_div_busy, 1'b0);

    // Asynchronous reset mid-ITER
    do_op("pre_reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    E_src1_div_cell = 32'd77; E_src2_div_cell = 32'd3; E_div_start = 1'b1;
    @(posedge clk); #1;
    E_div_start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("amid_busy", A_div_busy, 1'b0);
    chk("amid_done", A_div_done, 1'b0);
    chk("amid_quot", A_div_quot, 32'h0);
    chk("amid_rem", A_div_rem, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    do_op("post_reset", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

    // Edge-value sweep and random pairs against the reference model
    edges[0] = 32'h0;        edges[1] = 32'h1;        edges[2] = MINV;
    edges[3] = 32'h7FFF_FFFF; edges[4] = 32'hFFFF_FFFF; edges[5] = 32'd7;
    edges[6] = 32'hFFFF_FFF9;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 7; i++)
        for (int k = 0; k < 7; k++) begin
          ref_div(s[0], edges[i], edges[k], eq, er, ez);
          do_op($sformatf("edge_s%0d_%0d_%0d", s, i, k), s[0], edges[i], edges[k], eq, er, ez, 1'b0);
        end
    for (int n = 0; n < 30; n++) begin
      logic [DW-1:0] a, b;
      logic          sg;
      a  = $urandom;
      b  = (n % 3 == 0) ? DW'($urandom_range(1, 300)) : $urandom;
      sg = n[0];
      ref_div(sg, a, b, eq, er, ez);
      do_op($sformatf("rand%0d", n), sg, a, b, eq, er, ez, 1'b0);
    end

    repeat (3) @(posedge clk); #1;
    chk("done_count", n_done, n_exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
